// File: rtl/can_rx_filter_fifo_if.sv
// Receive-side bundle for can_rx_filter_fifo: frame strobe from the CAN packet layer,
// the rx_ack return, and the valid/ready FIFO output stream.
interface can_rx_filter_fifo_if #(
  parameter int unsigned DEPTH_LOG2 = 3
);
  logic                  rx_valid;
  logic [28:0]           rx_id;
  logic                  rx_ide;
  logic                  rx_rtr;
  logic [3:0]            rx_len;
  logic [63:0]           rx_data;
  logic                  rx_ack;

  logic                  o_valid;
  logic                  o_ready;
  logic [28:0]           o_id;
  logic                  o_ide;
  logic                  o_rtr;
  logic [3:0]            o_len;
  logic [63:0]           o_data;
  logic [DEPTH_LOG2:0]   o_level;

  // Filter/FIFO side
  modport slave (
    input  rx_valid, rx_id, rx_ide, rx_rtr, rx_len, rx_data, o_ready,
    output rx_ack, o_valid, o_id, o_ide, o_rtr, o_len, o_data, o_level
  );

  // Packet layer plus downstream consumer side
  modport master (
    output rx_valid, rx_id, rx_ide, rx_rtr, rx_len, rx_data, o_ready,
    input  rx_ack, o_valid, o_id, o_ide, o_rtr, o_len, o_data, o_level
  );
endinterface

// File: rtl/can_rx_filter_fifo.sv
// CAN receive ID acceptance filter feeding a first-word-fall-through FIFO, with ACK request.
// Optional macro CAN_RX_OVF_CNT_EN adds a saturating 16-bit count of frames dropped on a full FIFO.
module can_rx_filter_fifo #(
  parameter int unsigned DEPTH_LOG2     = 3,
  parameter logic [28:0] FILTER_ID      = 29'h0,
  parameter logic [28:0] FILTER_MASK    = 29'h0,
  parameter logic        FILTER_IDE     = 1'b0,
  parameter logic        FILTER_IDE_CHK = 1'b0,
  parameter logic        ACK_UNMATCHED  = 1'b1
) (
  input  logic                clk,
  input  logic                rstn,
  can_rx_filter_fifo_if.slave bus
`ifdef CAN_RX_OVF_CNT_EN
  ,
  output logic [15:0]         ovf_cnt
`endif
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2 + 1;

  typedef struct packed {
    logic [28:0] id;
    logic        ide;
    logic        rtr;
    logic [3:0]  len;
    logic [63:0] data;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        wr_entry;
  entry_t        head;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          rx_ack_q, rx_ack_d;
  logic          match, empty, full, push, pop;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    match    = (((bus.rx_id ^ FILTER_ID) & FILTER_MASK) == '0) &&
               (!FILTER_IDE_CHK || (bus.rx_ide == FILTER_IDE));
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
               (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
    // full is taken from the registered pointers, so a same-cycle pop never frees room for the push
    push     = bus.rx_valid && match && !full;
    pop      = !empty && bus.o_ready;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    rx_ack_d = rx_ack_q;
    if (bus.rx_valid) rx_ack_d = (match && !full) || (!match && ACK_UNMATCHED);

    wr_entry = '{id: bus.rx_id, ide: bus.rx_ide, rtr: bus.rx_rtr,
                 len: bus.rx_len, data: bus.rx_data};
    head     = empty ? '0 : mem_q[rd_ptr_q[PW-2:0]];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rx_ack_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rx_ack_q <= rx_ack_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers define validity and the head is gated when empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PW-2:0]] <= wr_entry;
  end

`ifdef CAN_RX_OVF_CNT_EN
  logic [15:0] ovf_cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_cnt_q <= '0;
    end else if (bus.rx_valid && match && full && (ovf_cnt_q != 16'hFFFF)) begin
      ovf_cnt_q <= ovf_cnt_q + 16'd1;
    end
  end

  assign ovf_cnt = ovf_cnt_q;
`endif

  assign bus.rx_ack  = rx_ack_q;
  assign bus.o_valid = !empty;
  assign bus.o_id    = head.id;
  assign bus.o_ide   = head.ide;
  assign bus.o_rtr   = head.rtr;
  assign bus.o_len   = head.len;
  assign bus.o_data  = head.data;
  assign bus.o_level = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_can_rx_filter_fifo.sv
// Directed bench for can_rx_filter_fifo: accept-all 4-deep instance (a) and a filtering,
// IDE-checked, non-ACKing-unmatched 8-deep instance (b).
module tb_can_rx_filter_fifo;

  logic clk;
  logic rstn;
  int   checks;
  int   failures;

  can_rx_filter_fifo_if #(.DEPTH_LOG2(2)) ifa ();
  can_rx_filter_fifo_if #(.DEPTH_LOG2(3)) ifb ();

`ifdef CAN_RX_OVF_CNT_EN
  logic [15:0] ovf_a;
  logic [15:0] ovf_b;
`endif

  can_rx_filter_fifo #(
    .DEPTH_LOG2(2)
  ) dut_a (
    .clk (clk),
    .rstn(rstn),
    .bus (ifa)
`ifdef CAN_RX_OVF_CNT_EN
    ,
    .ovf_cnt(ovf_a)
`endif
  );

  can_rx_filter_fifo #(
    .DEPTH_LOG2    (3),
    .FILTER_ID     (29'h456),
    .FILTER_MASK   (29'h7FF),
    .FILTER_IDE    (1'b0),
    .FILTER_IDE_CHK(1'b1),
    .ACK_UNMATCHED (1'b0)
  ) dut_b (
    .clk (clk),
    .rstn(rstn),
    .bus (ifb)
`ifdef CAN_RX_OVF_CNT_EN
    ,
    .ovf_cnt(ovf_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] frame_data(input int k);
    return (64'(k) * 64'h0101_0101_0101_0101) ^ 64'hDEAD_BEEF_0000_0000;
  endfunction

  // Called at a negedge: presents one frame for one clock and returns at the next negedge.
  task automatic send(input bit to_b, input logic [28:0] id, input logic ide, input logic rtr,
                      input logic [3:0] len, input logic [63:0] data);
    if (to_b) begin
      ifb.rx_valid = 1'b1; ifb.rx_id = id; ifb.rx_ide = ide;
      ifb.rx_rtr = rtr; ifb.rx_len = len; ifb.rx_data = data;
    end else begin
      ifa.rx_valid = 1'b1; ifa.rx_id = id; ifa.rx_ide = ide;
      ifa.rx_rtr = rtr; ifa.rx_len = len; ifa.rx_data = data;
    end
    @(negedge clk);
    ifa.rx_valid = 1'b0;
    ifb.rx_valid = 1'b0;
  endtask

  task automatic pop(input bit to_b);
    if (to_b) ifb.o_ready = 1'b1; else ifa.o_ready = 1'b1;
    @(negedge clk);
    ifa.o_ready = 1'b0;
    ifb.o_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (ifa.o_valid !== 1'b0) begin failures++; $display("FAIL reset_o_valid: got %0b exp 0", ifa.o_valid); end
    checks++; if (ifa.o_level !== 3'd0) begin failures++; $display("FAIL reset_o_level: got %0d exp 0", ifa.o_level); end
    checks++; if (ifa.rx_ack !== 1'b0) begin failures++; $display("FAIL reset_rx_ack: got %0b exp 0", ifa.rx_ack); end
    checks++; if (ifa.o_id !== 29'h0) begin failures++; $display("FAIL reset_o_id: got %0h exp 0", ifa.o_id); end
    checks++; if (ifa.o_data !== 64'h0) begin failures++; $display("FAIL reset_o_data: got %0h exp 0", ifa.o_data); end
    checks++; if (ifb.o_level !== 4'd0) begin failures++; $display("FAIL reset_b_level: got %0d exp 0", ifb.o_level); end
`ifdef CAN_RX_OVF_CNT_EN
    checks++; if (ovf_a !== 16'd0) begin failures++; $display("FAIL reset_ovf: got %0d exp 0", ovf_a); end
`endif
  endtask

  task automatic test_basic();
    checks++; if (ifa.o_valid !== 1'b0) begin failures++; $display("FAIL basic_pre_valid: got %0b exp 0", ifa.o_valid); end
    send(1'b0, 29'h123, 1'b0, 1'b0, 4'd2, 64'hBEEF);
    checks++; if (ifa.rx_ack !== 1'b1) begin failures++; $display("FAIL basic_ack: got %0b exp 1", ifa.rx_ack); end
    checks++; if (ifa.o_valid !== 1'b1) begin failures++; $display("FAIL basic_valid: got %0b exp 1", ifa.o_valid); end
    checks++; if (ifa.o_id !== 29'h123) begin failures++; $display("FAIL basic_id: got %0h exp 123", ifa.o_id); end
    checks++; if (ifa.o_len !== 4'd2) begin failures++; $display("FAIL basic_len: got %0d exp 2", ifa.o_len); end
    checks++; if (ifa.o_data[15:0] !== 16'hBEEF) begin failures++; $display("FAIL basic_data: got %0h exp beef", ifa.o_data[15:0]); end
    checks++; if (ifa.o_level !== 3'd1) begin failures++; $display("FAIL basic_level: got %0d exp 1", ifa.o_level); end
    pop(1'b0);
    checks++; if (ifa.o_valid !== 1'b0) begin failures++; $display("FAIL basic_pop_valid: got %0b exp 0", ifa.o_valid); end
    checks++; if (ifa.o_level !== 3'd0) begin failures++; $display("FAIL basic_pop_level: got %0d exp 0", ifa.o_level); end
    checks++; if (ifa.o_id !== 29'h0) begin failures++; $display("FAIL basic_empty_id: got %0h exp 0", ifa.o_id); end
    pop(1'b0);
    checks++; if (ifa.o_level !== 3'd0) begin failures++; $display("FAIL basic_pop_empty: got %0d exp 0", ifa.o_level); end
  endtask

  task automatic test_filter();
    send(1'b1, 29'h457, 1'b0, 1'b0, 4'd1, 64'h11);
    checks++; if (ifb.rx_ack !== 1'b0) begin failures++; $display("FAIL filt_reject_ack: got %0b exp 0", ifb.rx_ack); end
    checks++; if (ifb.o_level !== 4'd0) begin failures++; $display("FAIL filt_reject_level: got %0d exp 0", ifb.o_level); end
    send(1'b1, 29'h456, 1'b0, 1'b0, 4'd2, 64'h22);
    checks++; if (ifb.rx_ack !== 1'b1) begin failures++; $display("FAIL filt_accept_ack: got %0b exp 1", ifb.rx_ack); end
    checks++; if (ifb.o_id !== 29'h456) begin failures++; $display("FAIL filt_accept_id: got %0h exp 456", ifb.o_id); end
    checks++; if (ifb.o_level !== 4'd1) begin failures++; $display("FAIL filt_accept_level: got %0d exp 1", ifb.o_level); end
    send(1'b1, 29'h456, 1'b1, 1'b0, 4'd3, 64'h33);
    checks++; if (ifb.rx_ack !== 1'b0) begin failures++; $display("FAIL filt_ide_ack: got %0b exp 0", ifb.rx_ack); end
    checks++; if (ifb.o_level !== 4'd1) begin failures++; $display("FAIL filt_ide_level: got %0d exp 1", ifb.o_level); end
    send(1'b1, 29'h0ABCC456, 1'b0, 1'b1, 4'd8, 64'h44);
    checks++; if (ifb.rx_ack !== 1'b1) begin failures++; $display("FAIL filt_mask_ack: got %0b exp 1", ifb.rx_ack); end
    checks++; if (ifb.o_level !== 4'd2) begin failures++; $display("FAIL filt_mask_level: got %0d exp 2", ifb.o_level); end
    pop(1'b1);
    checks++; if (ifb.o_id !== 29'h0ABCC456) begin failures++; $display("FAIL filt_second_id: got %0h exp abcc456", ifb.o_id); end
    checks++; if (ifb.o_rtr !== 1'b1) begin failures++; $display("FAIL filt_second_rtr: got %0b exp 1", ifb.o_rtr); end
    checks++; if (ifb.o_len !== 4'd8) begin failures++; $display("FAIL filt_second_len: got %0d exp 8", ifb.o_len); end
    pop(1'b1);
    checks++; if (ifb.o_level !== 4'd0) begin failures++; $display("FAIL filt_drain_level: got %0d exp 0", ifb.o_level); end
  endtask

  logic [28:0] full_id  [4] = '{29'h1F000001, 29'h1F000002, 29'h1F000003, 29'h1F000004};
  logic [3:0]  full_len [4] = '{4'd9, 4'd10, 4'd15, 4'd3};

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      send(1'b0, full_id[i], 1'b0, 1'b0, full_len[i], frame_data(i));
      checks++; if (ifa.rx_ack !== 1'b1) begin failures++; $display("FAIL full_fill_ack[%0d]: got %0b exp 1", i, ifa.rx_ack); end
      checks++; if (ifa.o_level !== 3'(i + 1)) begin failures++; $display("FAIL full_fill_level[%0d]: got %0d exp %0d", i, ifa.o_level, i + 1); end
    end
    send(1'b0, 29'h555, 1'b0, 1'b0, 4'd1, 64'h55);
    checks++; if (ifa.rx_ack !== 1'b0) begin failures++; $display("FAIL full_drop_ack: got %0b exp 0", ifa.rx_ack); end
    checks++; if (ifa.o_level !== 3'd4) begin failures++; $display("FAIL full_drop_level: got %0d exp 4", ifa.o_level); end
    checks++; if (ifa.o_id !== full_id[0]) begin failures++; $display("FAIL full_head_id: got %0h exp %0h", ifa.o_id, full_id[0]); end
`ifdef CAN_RX_OVF_CNT_EN
    checks++; if (ovf_a !== 16'd1) begin failures++; $display("FAIL full_ovf: got %0d exp 1", ovf_a); end
`endif
  endtask

  task automatic test_push_pop_full();
    ifa.o_ready = 1'b1;
    send(1'b0, 29'h666, 1'b0, 1'b0, 4'd1, 64'h66);
    ifa.o_ready = 1'b0;
    checks++; if (ifa.o_level !== 3'd3) begin failures++; $display("FAIL ppfull_level: got %0d exp 3", ifa.o_level); end
    checks++; if (ifa.rx_ack !== 1'b0) begin failures++; $display("FAIL ppfull_ack: got %0b exp 0", ifa.rx_ack); end
`ifdef CAN_RX_OVF_CNT_EN
    checks++; if (ovf_a !== 16'd2) begin failures++; $display("FAIL ppfull_ovf: got %0d exp 2", ovf_a); end
`endif
    for (int i = 1; i < 4; i++) begin
      checks++; if (ifa.o_id !== full_id[i]) begin failures++; $display("FAIL drain_id[%0d]: got %0h exp %0h", i, ifa.o_id, full_id[i]); end
      checks++; if (ifa.o_len !== full_len[i]) begin failures++; $display("FAIL drain_len[%0d]: got %0d exp %0d", i, ifa.o_len, full_len[i]); end
      checks++; if (ifa.o_data !== frame_data(i)) begin failures++; $display("FAIL drain_data[%0d]: got %0h exp %0h", i, ifa.o_data, frame_data(i)); end
      pop(1'b0);
    end
    checks++; if (ifa.o_valid !== 1'b0) begin failures++; $display("FAIL drain_empty: got %0b exp 0", ifa.o_valid); end
  endtask

  task automatic test_back_to_back();
    ifa.o_ready = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) begin
        checks++; if (ifa.o_data !== frame_data(100 + k - 1) || ifa.o_id !== 29'(k - 1))
          begin failures++; $display("FAIL b2b_head[%0d]: got %0h/%0h exp %0h/%0h", k, ifa.o_id, ifa.o_data, k - 1, frame_data(100 + k - 1)); end
        checks++; if (ifa.o_level !== 3'd1 || ifa.rx_ack !== 1'b1)
          begin failures++; $display("FAIL b2b_level_ack[%0d]: got %0d/%0b exp 1/1", k, ifa.o_level, ifa.rx_ack); end
      end
      ifa.rx_valid = (k < 20);
      ifa.rx_id    = 29'(k);
      ifa.rx_ide   = 1'b0;
      ifa.rx_rtr   = 1'b0;
      ifa.rx_len   = 4'd8;
      ifa.rx_data  = frame_data(100 + k);
      @(negedge clk);
    end
    ifa.rx_valid = 1'b0;
    ifa.o_ready  = 1'b0;
    checks++; if (ifa.o_level !== 3'd0 || ifa.o_valid !== 1'b0)
      begin failures++; $display("FAIL b2b_end: got %0d/%0b exp 0/0", ifa.o_level, ifa.o_valid); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) send(1'b0, 29'h31 + 29'(i), 1'b0, 1'b0, 4'd4, frame_data(200 + i));
    checks++; if (ifa.o_level !== 3'd3) begin failures++; $display("FAIL rmid_pre_level: got %0d exp 3", ifa.o_level); end
    #2 rstn = 1'b0;
    #1;
    checks++; if (ifa.o_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid: got %0b exp 0", ifa.o_valid); end
    checks++; if (ifa.o_level !== 3'd0) begin failures++; $display("FAIL rmid_level: got %0d exp 0", ifa.o_level); end
    checks++; if (ifa.rx_ack !== 1'b0) begin failures++; $display("FAIL rmid_ack: got %0b exp 0", ifa.rx_ack); end
    checks++; if (ifa.o_id !== 29'h0) begin failures++; $display("FAIL rmid_id: got %0h exp 0", ifa.o_id); end
`ifdef CAN_RX_OVF_CNT_EN
    checks++; if (ovf_a !== 16'd0) begin failures++; $display("FAIL rmid_ovf: got %0d exp 0", ovf_a); end
`endif
    @(negedge clk);
    rstn = 1'b1;
    send(1'b0, 29'h7AB, 1'b0, 1'b0, 4'd5, 64'hCAFE);
    checks++; if (ifa.o_valid !== 1'b1 || ifa.o_id !== 29'h7AB)
      begin failures++; $display("FAIL rmid_after_head: got %0b/%0h exp 1/7ab", ifa.o_valid, ifa.o_id); end
    checks++; if (ifa.o_level !== 3'd1 || ifa.rx_ack !== 1'b1)
      begin failures++; $display("FAIL rmid_after_level_ack: got %0d/%0b exp 1/1", ifa.o_level, ifa.rx_ack); end
    pop(1'b0);
    checks++; if (ifa.o_level !== 3'd0) begin failures++; $display("FAIL rmid_after_pop: got %0d exp 0", ifa.o_level); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rstn     = 1'b0;
    ifa.rx_valid = 1'b0; ifa.rx_id = '0; ifa.rx_ide = 1'b0; ifa.rx_rtr = 1'b0;
    ifa.rx_len = '0; ifa.rx_data = '0; ifa.o_ready = 1'b0;
    ifb.rx_valid = 1'b0; ifb.rx_id = '0; ifb.rx_ide = 1'b0; ifb.rx_rtr = 1'b0;
    ifb.rx_len = '0; ifb.rx_data = '0; ifb.o_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rstn = 1'b1;
    @(negedge clk);
    test_basic();
    test_filter();
    test_full();
    test_push_pop_full();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
